// File: rtl/local_inj_ctrl_pkg.sv
// Shared widths, queue entry type and helpers for the local injection controller.
package local_inj_ctrl_pkg;

  localparam int FLIT_W   = 32;
  localparam int PV_W     = 4;
  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [PV_W-1:0]   pv;
  } entry_t;

  // Index of the set bit of a one-hot channel vector; 0 for an all-zero vector.
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [3:0] onehot);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (onehot[i]) idx = CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/local_inj_ctrl_rr_free_pick.sv
// Round-robin free-channel picker: first requesting channel at or above ptr,
// wrapping 3 -> 0, returned as a one-hot grant.
module rr_free_pick
  import local_inj_ctrl_pkg::*;
(
  input  logic [3:0]          req,
  input  logic [CH_IDX_W-1:0] ptr,
  output logic [3:0]          grant
);

  logic [CH_IDX_W-1:0] idx;
  logic                found;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + CH_IDX_W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/local_inj_ctrl.sv
// Local injection controller: circular queue of NI flits, injected into the
// first free N/E/S/W channel chosen round-robin, with a starvation flag.
module local_inj_ctrl
  import local_inj_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FLIT_W-1:0]        ni_flit,
  input  logic [PV_W-1:0]          ni_pv,
  input  logic                     ni_valid,
  output logic                     ni_ready,
  input  logic [3:0]               ch_valid,
  output logic [FLIT_W-1:0]        inj_flit,
  output logic [PV_W-1:0]          inj_pv,
  output logic [3:0]               inj_sel,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  entry_t              mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [OCC_W-1:0]    occ;
  logic [CH_IDX_W-1:0] rr_ptr;
  logic [7:0]          blk_cnt;

  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                inject;
  logic [3:0]          free;
  logic [3:0]          grant;
  entry_t              head;

  assign empty  = (occ == '0);
  assign full   = (occ == OCC_W'(DEPTH));
  assign free   = ~ch_valid;

  // Outputs show reset values while reset is held, not only after the edge.
  assign inject = !reset && !empty && (|free);
  assign push   = !reset && ni_valid && !full;
  assign pop    = inject;

  rr_free_pick u_pick (
    .req   (free),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign head = mem[rd_ptr];

  always_comb begin
    ni_ready  = reset || !full;
    inj_sel   = inject ? grant : 4'b0000;
    inj_flit  = '0;
    inj_pv    = '0;
    if (!reset && !empty) begin
      inj_flit = head.flit;
      inj_pv   = head.pv;
    end
    starve    = !reset && (blk_cnt == 8'(STARVE_LIMIT));
    occupancy = occ;
  end

  // NOTE: queue storage has no reset; readers only see it through the empty mask.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{flit: ni_flit, pv: ni_pv};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      rr_ptr  <= '0;
      blk_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      if (inject) rr_ptr <= onehot_to_idx(grant) + CH_IDX_W'(1);

      // Counts consecutive cycles in which a queued head could not leave.
      if (inject || empty) begin
        blk_cnt <= '0;
      end else if (blk_cnt != 8'(STARVE_LIMIT)) begin
        blk_cnt <= blk_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_local_inj_ctrl.sv
// Directed self-checking bench for local_inj_ctrl (DEPTH=4, STARVE_LIMIT=8).
module tb_local_inj_ctrl;
  import local_inj_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] ni_flit;
  logic [PV_W-1:0]   ni_pv;
  logic              ni_valid;
  logic              ni_ready;
  logic [3:0]        ch_valid;
  logic [FLIT_W-1:0] inj_flit;
  logic [PV_W-1:0]   inj_pv;
  logic [3:0]        inj_sel;
  logic              starve;
  logic [$clog2(DEPTH):0] occupancy;

  int total = 0;
  int bad   = 0;

  local_inj_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ni_flit   (ni_flit),
    .ni_pv     (ni_pv),
    .ni_valid  (ni_valid),
    .ni_ready  (ni_ready),
    .ch_valid  (ch_valid),
    .inj_flit  (inj_flit),
    .inj_pv    (inj_pv),
    .inj_sel   (inj_sel),
    .starve    (starve),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [FLIT_W-1:0] f, input logic [PV_W-1:0] p,
                       input logic [3:0] ch);
    ni_valid = v;
    ni_flit  = f;
    ni_pv    = p;
    ch_valid = ch;
    #1;
  endtask

  logic [FLIT_W-1:0] q_flit [$];
  logic [1:0]        rr_exp;
  logic [FLIT_W-1:0] f_tmp;

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_0000, 4'hF, 4'b0000);
    check("rst_ready", 64'(ni_ready), 64'd1);
    check("rst_sel", 64'(inj_sel), 64'd0);
    check("rst_flit", 64'(inj_flit), 64'd0);
    check("rst_starve", 64'(starve), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 4'b0000);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("empty_no_inj_sel", 64'(inj_sel), 64'd0);
    check("empty_flit_zero", 64'(inj_flit), 64'd0);

    // Push A, then free only S: scan from rr_ptr=0 lands on S.
    drive(1'b1, 32'h0000_00A0, 4'h3, 4'b1111);
    check("a_ready", 64'(ni_ready), 64'd1);
    tick();
    drive(1'b0, '0, '0, 4'b1111);
    check("a_visible", 64'(inj_flit), 64'h0000_00A0);
    check("a_pv", 64'(inj_pv), 64'h3);
    check("a_blocked_sel", 64'(inj_sel), 64'd0);
    check("a_occ1", 64'(occupancy), 64'd1);
    drive(1'b0, '0, '0, 4'b1011);
    check("a_sel_s", 64'(inj_sel), 64'b0100);
    tick();
    check("a_occ0", 64'(occupancy), 64'd0);
    check("a_gone_flit", 64'(inj_flit), 64'd0);
    check("a_gone_pv", 64'(inj_pv), 64'd0);

    // rr_ptr is now 3: all free picks W, then wraps to N.
    drive(1'b1, 32'h0000_00B0, 4'h1, 4'b1111);
    tick();
    drive(1'b1, 32'h0000_00C0, 4'h2, 4'b1111);
    tick();
    drive(1'b0, '0, '0, 4'b0000);
    check("b_occ2", 64'(occupancy), 64'd2);
    check("b_sel_w", 64'(inj_sel), 64'b1000);
    check("b_flit", 64'(inj_flit), 64'h0000_00B0);
    tick();
    check("c_sel_n", 64'(inj_sel), 64'b0001);
    check("c_flit", 64'(inj_flit), 64'h0000_00C0);
    tick();
    check("c_occ0", 64'(occupancy), 64'd0);

    // Fill the queue; a fifth offer is refused.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h0000_0D00 + 32'(i), 4'(i), 4'b1111);
      check("fill_ready", 64'(ni_ready), 64'd1);
      tick();
    end
    drive(1'b1, 32'h0000_0EEE, 4'hE, 4'b1111);
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_ready", 64'(ni_ready), 64'd0);
    tick();
    check("full_no_accept", 64'(occupancy), 64'd4);
    // rr_ptr is 1 here; only N free, so every pick is N. Full blocks push even on pop.
    drive(1'b1, 32'h0000_0EEE, 4'hE, 4'b1110);
    check("full_pop_ready", 64'(ni_ready), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) drive(1'b0, '0, '0, 4'b1110);
      check("drain_flit", 64'(inj_flit), 64'(32'h0000_0D00 + 32'(i)));
      check("drain_pv", 64'(inj_pv), 64'(i));
      check("drain_sel", 64'(inj_sel), 64'b0001);
      check("drain_occ", 64'(occupancy), 64'(DEPTH - i));
      tick();
    end
    check("drain_empty", 64'(occupancy), 64'd0);

    // Starvation: one flit, all channels busy.
    drive(1'b1, 32'h0000_00E0, 4'h5, 4'b1111);
    tick();
    drive(1'b0, '0, '0, 4'b1111);
    for (int i = 1; i <= LIMIT + 1; i++) begin
      tick();
      if (i == LIMIT - 1) check("starve_before", 64'(starve), 64'd0);
      if (i == LIMIT)     check("starve_at", 64'(starve), 64'd1);
      if (i == LIMIT + 1) check("starve_hold", 64'(starve), 64'd1);
    end
    check("starve_occ", 64'(occupancy), 64'd1);
    drive(1'b0, '0, '0, 4'b1101);
    check("starve_sel_e", 64'(inj_sel), 64'b0010);
    check("starve_still", 64'(starve), 64'd1);
    tick();
    check("starve_drop", 64'(starve), 64'd0);
    check("starve_occ0", 64'(occupancy), 64'd0);

    // Steady push+pop at occupancy 2 across three laps of the queue.
    rr_exp = 2'd2;
    drive(1'b1, 32'h0000_0F00, 4'h0, 4'b1111);
    tick();
    drive(1'b1, 32'h0000_0F01, 4'h1, 4'b1111);
    tick();
    q_flit.push_back(32'h0000_0F00);
    q_flit.push_back(32'h0000_0F01);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      f_tmp = 32'h0000_1000 + 32'(i);
      drive(1'b1, f_tmp, 4'(i), 4'b0000);
      check("lap_occ", 64'(occupancy), 64'd2);
      check("lap_flit", 64'(inj_flit), 64'(q_flit[0]));
      check("lap_sel", 64'(inj_sel), 64'(4'b0001 << rr_exp));
      tick();
      void'(q_flit.pop_front());
      q_flit.push_back(f_tmp);
      rr_exp = rr_exp + 2'd1;
    end
    drive(1'b0, '0, '0, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      check("lap_tail_flit", 64'(inj_flit), 64'(q_flit[0]));
      tick();
      void'(q_flit.pop_front());
    end
    check("lap_empty", 64'(occupancy), 64'd0);

    // Reset mid-operation with three queued flits and starve raised.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(i), 4'(i), 4'b1111);
      tick();
    end
    drive(1'b0, '0, '0, 4'b1111);
    for (int i = 0; i < LIMIT - 2; i++) tick();
    check("pre_rst_occ", 64'(occupancy), 64'd3);
    check("pre_rst_starve", 64'(starve), 64'd1);
    reset = 1'b1;
    drive(1'b1, 32'h0000_3000, 4'h9, 4'b0000);
    check("in_rst_sel", 64'(inj_sel), 64'd0);
    check("in_rst_ready", 64'(ni_ready), 64'd1);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 4'b0000);
    check("post_rst_occ", 64'(occupancy), 64'd0);
    check("post_rst_starve", 64'(starve), 64'd0);
    check("post_rst_sel", 64'(inj_sel), 64'd0);
    check("post_rst_ready", 64'(ni_ready), 64'd1);
    check("post_rst_flit", 64'(inj_flit), 64'd0);
    tick();
    check("rst_push_dropped", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/local_inj_ctrl.md
LOCAL_INJ_CTRL -- requirements
Module: local_inj_ctrl

Interface
REQ-001 Parameter DEPTH, 4, injection queue entries; power of two, minimum 2.
REQ-002 Parameter STARVE_LIMIT, 8, consecutive blocked cycles before starve is asserted; range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ni_flit  input  `WIDTH_PORT  flit offered by the network interface.
REQ-006 ni_pv  input  `WIDTH_PV  productive-port vector of ni_flit.
REQ-007 ni_valid  input  1  ni_flit and ni_pv are valid.
REQ-008 ni_ready  output  1  queue accepts a flit this cycle.
REQ-009 ch_valid  input  4  valid bits of the N, E, S and W channels (bit 0 = N) at the allocation stage.
REQ-010 inj_flit  output  `WIDTH_PORT  head flit presented for injection.
REQ-011 inj_pv  output  `WIDTH_PV  head flit PV.
REQ-012 inj_sel  output  4  one-hot free channel granted to the head flit; all zero when there is no injection.
REQ-013 starve  output  1  the head flit has been blocked for STARVE_LIMIT or more cycles.
REQ-014 occupancy  output  $clog2(DEPTH)+1  number of queued flits.

Function
REQ-015 Circular FIFO with registered read/write pointers; a push occurs when ni_valid and ni_ready are both high.
REQ-016 ni_ready = (occupancy != DEPTH); no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 A flit pushed at edge N is visible on inj_flit/inj_pv starting in cycle N+1; an empty queue never injects combinationally.
REQ-018 free = ~ch_valid; inject = (occupancy != 0) && |free; a pop occurs at the edge that ends an inject cycle.
REQ-019 inj_sel is combinational: the first free channel scanning upward from rr_ptr, wrapping 3->0; zero when inject is low.
REQ-020 rr_ptr is 2 bits; on inject, rr_ptr <= (granted index + 1) mod 4; otherwise it holds.
REQ-021 When inject is low, inj_flit and inj_pv output the head entry, or all zeros if the queue is empty.
REQ-022 A push and a pop in the same cycle leave occupancy unchanged; both pointers advance and wrap modulo DEPTH.
REQ-023 blk_cnt (8-bit): cleared on inject or when the queue is empty; otherwise incremented, saturating at STARVE_LIMIT.
REQ-024 starve = (blk_cnt == STARVE_LIMIT); it drops in the cycle after the blocked flit is injected.
REQ-025 Queue data written on a push is a registered copy; ni_flit/ni_pv are not sampled at any other time.

Reset
REQ-026 Reset asserted at any edge, including mid-operation, clears the pointers, occupancy, rr_ptr and blk_cnt, and discards all queued flits.
REQ-027 Output values during and after reset: ni_ready=1, inj_sel=0, inj_flit=0, inj_pv=0, starve=0, occupancy=0.
REQ-028 A push requested in the reset cycle is dropped.
REQ-029 FIFO storage contents are not reset; outputs are masked by the empty condition.

Structure
REQ-030 `WIDTH_PORT, `WIDTH_PV and `NUM_CHANNEL come from global.vh; no new global macros are added.
REQ-031 The round-robin free-slot picker is one combinational sub-module, rr_free_pick (4-bit request, 2-bit pointer, 4-bit one-hot grant).
REQ-032 The FIFO is inline; no other sub-modules.

Verification
REQ-033 After reset, push A with ch_valid=4'b1111, then set ch_valid=4'b1011 -> inj_sel=4'b0100, A is popped, rr_ptr=3, occupancy 1->0.
REQ-034 rr_ptr=3 and ch_valid=4'b0000 -> inj_sel=4'b1000; in the next cycle, with the queue non-empty, inj_sel=4'b0001.
REQ-035 Push 4 flits with ch_valid=4'b1111 -> occupancy=4, ni_ready=0; a further ni_valid is not accepted; flits exit in FIFO order once slots free.
REQ-036 One queued flit with ch_valid=4'b1111 held for 8 cycles -> starve=1 from the 8th cycle; free a channel -> the flit injects and starve=0 in the next cycle.
REQ-037 Occupancy 2, simultaneous push and inject -> occupancy stays 2; pointers wrap correctly across 3 laps of DEPTH.
REQ-038 Reset asserted with occupancy 3 and starve=1 -> next cycle occupancy=0, starve=0, inj_sel=0, ni_ready=1.
